// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_e    : loader FSM states (3-bit encoding, 8 states)
//   LEN_BYTES  : number of length bytes at the head of a stream
//   WORD_BYTES : number of bytes per instruction word
//   is_busy()  : true for the states in which a load is in progress
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic is_busy(input state_e s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) ||
               (s == S_WRITE)  || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler with running XOR checksum.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the byte index and checksum (start of a load)
//   shift      : accept byte_in this cycle
//   byte_in    : data byte
//   word       : assembled big-endian word (first byte ends up in [31:24])
//   byte_idx   : position of the next byte within the word
//   csum       : XOR of all bytes shifted since the last clear
//   last_byte  : this shift completes a word
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_idx,
    output logic [7:0]  csum,
    output logic        last_byte
);

    assign last_byte = shift && (byte_idx == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_idx <= '0;
            csum     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            csum     <= '0;
        end else if (shift) begin
            // Shifting left makes the first byte of the word land in [31:24].
            word     <= {word[23:0], byte_in};
            csum     <= csum ^ byte_in;
            // Index wraps to 0 after the fourth byte.
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction
// memory while holding the CPU pipeline in reset.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a load (ignored while busy)
//   abort             : cancel a load in progress
//   byte_in/valid     : input byte stream; byte_ready is the handshake
//   imem_we/addr/wdata: instruction-memory write port
//   cpu_hold          : keep the CPU pipeline in reset
//   done / error      : outcome of the last load
//   word_count        : words written in the current or last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_e      state, state_nx;
    logic [15:0] len_q;
    logic        busy, xfer, clear, shift, last_byte;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [15:0] len_now;
    logic [16:0] wc_inc;

    assign busy    = is_busy(state);
    assign xfer    = byte_valid && byte_ready;
    assign len_now = {len_q[15:8], byte_in};
    assign wc_inc  = 17'(word_count) + 17'd1;

    loader_word_asm u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift     (shift),
        .byte_in   (byte_in),
        .word      (imem_wdata),
        .byte_idx  (byte_idx),
        .csum      (csum),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        shift    = 1'b0;
        if (busy && abort) begin
            // Abort wins over any byte transfer in the same cycle.
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_nx = S_LEN_HI;
                        clear    = 1'b1;
                    end
                end
                S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
                S_LEN_LO: begin
                    if (xfer) begin
                        if (len_now == 16'd0)                state_nx = S_CHECK;
                        else if (17'(len_now) > MAX_WORDS)   state_nx = S_ERROR;
                        else                                 state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    shift = xfer;
                    if (last_byte) state_nx = S_WRITE;
                end
                S_WRITE: state_nx = (wc_inc < 17'(len_q)) ? S_DATA : S_CHECK;
                S_CHECK: begin
                    if (xfer) state_nx = (byte_in == csum) ? S_DONE : S_ERROR;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_count <= '0;
        end else if (clear) begin
            word_count <= '0;
        end else if (!(busy && abort)) begin
            if (state == S_LEN_HI && xfer) len_q[15:8] <= byte_in;
            if (state == S_LEN_LO && xfer) len_q[7:0]  <= byte_in;
            if (state == S_WRITE)          word_count  <= word_count + 1'b1;
        end
    end

    assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign imem_we    = (state == S_WRITE) && !abort;
    assign imem_addr  = word_count[ADDR_W-1:0];
    assign cpu_hold   = busy || (state == S_ERROR);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level reference model
// predicts the memory writes and final status; a monitor checks every
// write pulse against the predicted queue.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready, imem_we, cpu_hold, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic [7:0]        stream[$];
    logic              m_done, m_err;
    int                m_wc;
    logic [7:0]        m_csum;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: interprets the whole stream and queues expected writes.
    task automatic model();
        int n;
        n = {stream[0], stream[1]};
        m_csum = 8'h00; m_wc = 0; m_done = 1'b0; m_err = 1'b0;
        if (n > (1 << ADDR_W)) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = {stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]};
            for (int k = 0; k < 4; k++) m_csum ^= stream[2+4*i+k];
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back(w);
            m_wc++;
        end
        m_done = (stream[2+4*n] == m_csum);
        m_err  = !m_done;
    endtask

    task automatic append_checksum();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 2; i < stream.size(); i++) c ^= stream[i];
        stream.push_back(c);
    endtask

    // Write monitor: every write must match the next predicted write.
    always @(negedge clk) begin
        #1;
        if (rst_n && imem_we) begin
            if (exp_addr.size() == 0) chk("stray_we", 64'(imem_we), 64'd0);
            else begin
                chk("we_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
                chk("we_data", 64'(imem_wdata), 64'(exp_data.pop_front()));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_stream(input int gapmod);
        int n;
        n = {stream[0], stream[1]};
        foreach (stream[i]) begin
            send_byte(stream[i], (gapmod > 0) ? (i % gapmod) : 0);
            // Write strobe must appear the cycle right after the 4th data byte.
            if (i == 5 && n != 0 && n <= (1 << ADDR_W)) begin
                #1 chk("latency_we", 64'(imem_we), 64'd1);
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold", 64'(cpu_hold), 64'd1);
        chk("start_wc", 64'(word_count), 64'd0);
        chk("start_flags", 64'({done, error}), 64'd0);
    endtask

    task automatic check_end(input string name);
        chk({name, "_done"}, 64'(done), 64'(m_done));
        chk({name, "_error"}, 64'(error), 64'(m_err));
        chk({name, "_wc"}, 64'(word_count), 64'(m_wc));
        chk({name, "_hold"}, 64'(cpu_hold), 64'(m_err));
        chk({name, "_pending"}, 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_ready"}, 64'(byte_ready), 64'd0);
        chk({name, "_we"}, 64'(imem_we), 64'd0);
        chk({name, "_addr"}, 64'(imem_addr), 64'd0);
        chk({name, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({name, "_hold"}, 64'(cpu_hold), 64'd0);
        chk({name, "_flags"}, 64'({done, error}), 64'd0);
        chk({name, "_wc"}, 64'(word_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // S1: two words, correct checksum. Pin the model with literals.
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'hAC, 8'h08, 8'h00, 8'h04, 8'h8D};
        model();
        chk("pin_csum", 64'(m_csum), 64'h8D);
        chk("pin_w0", 64'(exp_data[0]), 64'h20080005);
        chk("pin_w1", 64'(exp_data[1]), 64'hAC080004);
        chk("pin_done", 64'(m_done), 64'd1);
        do_start();
        run_stream(0);
        check_end("s1");
        chk("s1_ready_done", 64'(byte_ready), 64'd0);

        // S2: same stream, bad checksum: words still written, error.
        stream[10] = 8'h25;
        model();
        chk("pin_err", 64'(m_err), 64'd1);
        do_start();
        run_stream(0);
        check_end("s2");

        // S3: empty image.
        stream = '{8'h00, 8'h00, 8'h00};
        model();
        do_start();
        run_stream(0);
        check_end("s3");

        // S4: length 257 exceeds memory: error after length bytes.
        stream = '{8'h01, 8'h01};
        model();
        do_start();
        run_stream(0);
        check_end("s4");
        chk("s4_ready", 64'(byte_ready), 64'd0);

        // S5: abort coincident with the 4th data byte.
        do_start();
        stream = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        foreach (stream[i]) send_byte(stream[i], 0);
        byte_in = 8'hDD; byte_valid = 1'b1; abort = 1'b1;
        #1 chk("s5_we_suppressed", 64'(imem_we), 64'd0);
        @(negedge clk);
        byte_valid = 1'b0; abort = 1'b0;
        chk("s5_hold", 64'(cpu_hold), 64'd0);
        chk("s5_flags", 64'({done, error}), 64'd0);
        chk("s5_ready", 64'(byte_ready), 64'd0);
        repeat (3) @(negedge clk);

        // S6: gaps of 0-7 cycles with start held high throughout.
        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                   8'hDE, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04};
        append_checksum();
        model();
        do_start();
        start = 1'b1;
        run_stream(8);
        start = 1'b0;
        check_end("s6");

        // S7: full memory (256 words).
        stream = '{8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) stream.push_back(8'(i * 7 + 3));
        append_checksum();
        model();
        do_start();
        run_stream(0);
        check_end("s7");

        // S8: asynchronous reset in the middle of DATA.
        exp_addr.push_back('0);
        exp_data.push_back(32'h11223344);
        do_start();
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (stream[i]) send_byte(stream[i], 0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("s8");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s8_pending", 64'(exp_addr.size()), 64'd0);
        chk("s8_idle_hold", 64'(cpu_hold), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
